// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: operation encoding, FSM states and
// the cycle-count helper ceil(shamt/STEP).
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic int step_count(input int shamt, input int step);
    return (shamt + step - 1) / step;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP bits.
// SRA takes its fill bit from outside so the sign survives across iterations.
module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  shift_op_t          op,
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W:0]   amt,
  input  logic               fill,
  output logic [XLEN-1:0]    shifted
);

  localparam logic [XLEN-1:0] ONES = '1;

  always_comb begin
    shifted = data;
    case (op)
      SHIFT_SLL: shifted = data << amt;
      SHIFT_SRL: shifted = data >> amt;
      // Vacated MSBs take the fill bit rather than the current data MSB.
      SHIFT_SRA: shifted = fill ? ((data >> amt) | ~(ONES >> amt)) : (data >> amt);
      default:   shifted = data;
    endcase
  end

endmodule

// File: rtl/shift_unit_iter.sv
// Iterative multicycle shifter: shifts by up to STEP bits per clock, with
// valid/ready handshakes on request and result sides.
module shift_unit_iter
  import shift_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               busy
);

  localparam logic [SHAMT_W:0] STEP_K = (SHAMT_W + 1)'(STEP);

  state_t             state, state_nx;
  logic [XLEN-1:0]    acc, acc_step;
  logic [SHAMT_W-1:0] rem;
  shift_op_t          op_q;
  logic [SHAMT_W:0]   k;
  logic               last;
  logic               accept;

  assign k      = ({1'b0, rem} >= STEP_K) ? STEP_K : {1'b0, rem};
  assign last   = ({1'b0, rem} == k);
  assign accept = in_valid && (state == IDLE);

  shift_step #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_step (
    .op      (op_q),
    .data    (acc),
    .amt     (k),
    .fill    (acc[XLEN-1]),
    .shifted (acc_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        // Reserved op behaves like a zero shift: straight to DONE.
        if (in_valid)
          state_nx = ((shamt == '0) || (op == SHIFT_RSVD)) ? DONE : SHIFT;
      end
      SHIFT: if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: acc/rem/op only load on acceptance, so later input changes are invisible.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc  <= a;
      rem  <= shamt;
      op_q <= shift_op_t'(op);
    end else if (state == SHIFT) begin
      acc <= acc_step;
      rem <= rem - k[SHAMT_W-1:0];
    end
  end

  assign result = (state == DONE) ? acc : '0;

endmodule
